// File: rtl/linha_pkg.sv
// rtl/linha_pkg.sv - state encoding and default parameters for the bottling station sequencer
package linha_pkg;

  localparam int ESTADO_W            = 3;
  localparam int DUZIA_DEF           = 12;
  localparam int TIMEOUT_CICLOS_DEF  = 1000;
  localparam int INSPECAO_CICLOS_DEF = 8;
  localparam int DUZIAS_W_DEF        = 8;

  // FALHA lives outside the 3-bit display code and is reported as 7 plus the alarm flag
  typedef enum logic [3:0] {
    S_PARADO        = 4'd0,
    S_AVANCA        = 4'd1,
    S_ENCHENDO      = 4'd2,
    S_VEDANDO       = 4'd3,
    S_INSPECIONANDO = 4'd4,
    S_DESCARTE      = 4'd5,
    S_LIBERA        = 4'd6,
    S_CAIXA_CHEIA   = 4'd7,
    S_FALHA         = 4'd8
  } estado_t;

endpackage

// File: rtl/controlador_linha_envase_temporizador_watchdog.sv
// rtl/controlador_linha_envase_temporizador_watchdog.sv - per-state cycle counter, flags LIMITE-1 cycles
module temporizador_watchdog
  import linha_pkg::*;
#(
  parameter int LIMITE = TIMEOUT_CICLOS_DEF
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expirado
);

  localparam int W = (LIMITE > 2) ? $clog2(LIMITE) : 1;

  logic [W-1:0] contagem_q, contagem_d;

  assign expirado = (contagem_q == W'(LIMITE - 1));

  // Holds at the limit so the flag stays up until the owner leaves the state
  always_comb begin
    contagem_d = contagem_q;
    if (clear)
      contagem_d = '0;
    else if (enable && !expirado)
      contagem_d = contagem_q + 1'b1;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) contagem_q <= '0;
    else       contagem_q <= contagem_d;
  end

endmodule

// File: rtl/controlador_linha_envase.sv
// rtl/controlador_linha_envase.sv - master sequencer for one bottling station (conveyor, filler, sealer, quality)
// Optional reject counter and three-reject fault enabled by CONTADOR_REJEITADAS_EN.
module controlador_linha_envase
  import linha_pkg::*;
#(
  parameter int DUZIA           = DUZIA_DEF,
  parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_DEF,
  parameter int INSPECAO_CICLOS = INSPECAO_CICLOS_DEF,
  parameter int DUZIAS_W        = DUZIAS_W_DEF
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                START,
  input  logic                STOP,
  input  logic                GARRAFA_POSICIONADA,
  input  logic                GARRAFA_CHEIA,
  input  logic                GARRAFA_VEDADA,
  input  logic                GARRAFA_APROVADA,
  input  logic                TROCA_CAIXA,
  input  logic                RECONHECE_FALHA,
  output logic                MOTOR_ESTEIRA,
  output logic                CMD_ENCHER,
  output logic                CMD_VEDAR,
  output logic                CMD_DESCARTE,
  output logic [3:0]          CONTAGEM_GARRAFAS,
  output logic [DUZIAS_W-1:0] CONTAGEM_DUZIAS,
  output logic                CAIXA_CHEIA,
  output logic                ALARME_FALHA,
  output logic [ESTADO_W-1:0] ESTADO
`ifdef CONTADOR_REJEITADAS_EN
  ,
  output logic [7:0]          CONTAGEM_REJEITADAS
`endif
);

  estado_t             estado_q, estado_d;
  logic [3:0]          garrafas_q, garrafas_d;
  logic [DUZIAS_W-1:0] duzias_q, duzias_d;
  logic                troca_estado, wd_en, wd_exp, jan_exp, falha_rej, aprovou;

  assign troca_estado = (estado_d != estado_q);
  assign wd_en = estado_q inside {S_AVANCA, S_ENCHENDO, S_VEDANDO, S_LIBERA};
  assign aprovou = (estado_q == S_INSPECIONANDO) && GARRAFA_APROVADA;

  temporizador_watchdog #(.LIMITE(TIMEOUT_CICLOS)) u_watchdog (
    .CLOCK(CLOCK), .RESET(RESET), .clear(troca_estado), .enable(wd_en), .expirado(wd_exp)
  );

  temporizador_watchdog #(.LIMITE(INSPECAO_CICLOS)) u_janela (
    .CLOCK(CLOCK), .RESET(RESET), .clear(troca_estado),
    .enable(estado_q == S_INSPECIONANDO), .expirado(jan_exp)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      estado_q   <= S_PARADO;
      garrafas_q <= '0;
      duzias_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      garrafas_q <= garrafas_d;
      duzias_q   <= duzias_d;
    end
  end

  // Exit conditions are tested before the watchdog so a same-cycle exit wins
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      S_PARADO:        if (START && !STOP) estado_d = S_AVANCA;
      S_AVANCA:        if (GARRAFA_POSICIONADA) estado_d = S_ENCHENDO;
                       else if (wd_exp) estado_d = S_FALHA;
      S_ENCHENDO:      if (GARRAFA_CHEIA) estado_d = S_VEDANDO;
                       else if (wd_exp) estado_d = S_FALHA;
      S_VEDANDO:       if (GARRAFA_VEDADA) estado_d = S_INSPECIONANDO;
                       else if (wd_exp) estado_d = S_FALHA;
      S_INSPECIONANDO: if (GARRAFA_APROVADA) estado_d = S_LIBERA;
                       else if (jan_exp) estado_d = S_DESCARTE;
      S_DESCARTE:      estado_d = falha_rej ? S_FALHA : S_LIBERA;
      S_LIBERA: begin
        if (!GARRAFA_POSICIONADA) begin
          if (garrafas_q == 4'(DUZIA))  estado_d = S_CAIXA_CHEIA;
          else if (STOP || !START)      estado_d = S_PARADO;
          else                          estado_d = S_AVANCA;
        end else if (wd_exp) begin
          estado_d = S_FALHA;
        end
      end
      S_CAIXA_CHEIA:   if (TROCA_CAIXA) estado_d = STOP ? S_PARADO : S_AVANCA;
      S_FALHA:         if (RECONHECE_FALHA) estado_d = S_PARADO;
      default:         estado_d = S_PARADO;
    endcase
  end

  always_comb begin
    garrafas_d = garrafas_q;
    duzias_d   = duzias_q;
    if (aprovou)
      garrafas_d = garrafas_q + 4'd1;
    if ((estado_q == S_CAIXA_CHEIA) && TROCA_CAIXA) begin
      garrafas_d = '0;
      duzias_d   = duzias_q + 1'b1;
    end
  end

`ifdef CONTADOR_REJEITADAS_EN
  logic [7:0] rejeitadas_q, rejeitadas_d;
  logic [1:0] consec_q, consec_d;

  always_comb begin
    rejeitadas_d = rejeitadas_q;
    consec_d     = consec_q;
    if ((estado_q == S_INSPECIONANDO) && (estado_d == S_DESCARTE)) begin
      if (rejeitadas_q != 8'hFF) rejeitadas_d = rejeitadas_q + 8'd1;
      if (consec_q != 2'd3)      consec_d     = consec_q + 2'd1;
    end
    // The streak is spent once it has raised a fault
    if (aprovou || (estado_q == S_FALHA))
      consec_d = '0;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rejeitadas_q <= '0;
      consec_q     <= '0;
    end else begin
      rejeitadas_q <= rejeitadas_d;
      consec_q     <= consec_d;
    end
  end

  assign falha_rej           = (consec_q == 2'd3);
  assign CONTAGEM_REJEITADAS = rejeitadas_q;
`else
  assign falha_rej = 1'b0;
`endif

  always_comb begin
    MOTOR_ESTEIRA = 1'b0;
    CMD_ENCHER    = 1'b0;
    CMD_VEDAR     = 1'b0;
    CMD_DESCARTE  = 1'b0;
    CAIXA_CHEIA   = 1'b0;
    ALARME_FALHA  = 1'b0;
    ESTADO        = estado_q[ESTADO_W-1:0];
    case (estado_q)
      S_AVANCA, S_LIBERA: MOTOR_ESTEIRA = 1'b1;
      S_ENCHENDO:         CMD_ENCHER    = 1'b1;
      S_VEDANDO:          CMD_VEDAR     = 1'b1;
      S_DESCARTE:         CMD_DESCARTE  = 1'b1;
      S_CAIXA_CHEIA:      CAIXA_CHEIA   = 1'b1;
      S_FALHA: begin
        ALARME_FALHA = 1'b1;
        ESTADO       = 3'd7;
      end
      default: ;
    endcase
  end

  assign CONTAGEM_GARRAFAS = garrafas_q;
  assign CONTAGEM_DUZIAS   = duzias_q;

endmodule

// File: doc/controlador_linha_envase.md
Name: controlador_linha_envase

Overview:
- Master sequencer for one bottling station on the wine line.
- Drives the conveyor, commands the filler and sealer FSMs, and waits for the quality FSM's verdict.
- Counts approved bottles into dozens (one box = DUZIA bottles) and raises a watchdog fault when any station stalls.
- Sits above the enchimento, vedação and qualidade FSMs; its outputs drive their start/command inputs.

Parameters:
- DUZIA, 12, approved bottles per box.
- TIMEOUT_CICLOS, 1000, maximum cycles allowed in any motion/station state before fault.
- INSPECAO_CICLOS, 8, cycles the inspection window stays open for GARRAFA_APROVADA.
- DUZIAS_W, 8, width of the dozen counter.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-high; returns block to PARADO with all counters zero.
- START  in  1  level; line enable.
- STOP  in  1  level; graceful stop request, honoured only at a bottle boundary.
- GARRAFA_POSICIONADA  in  1  presence sensor at the station.
- GARRAFA_CHEIA  in  1  done flag from the filler FSM.
- GARRAFA_VEDADA  in  1  done flag from the sealer FSM.
- GARRAFA_APROVADA  in  1  level from the quality FSM.
- TROCA_CAIXA  in  1  operator acknowledge that the full box was replaced.
- RECONHECE_FALHA  in  1  operator fault acknowledge.
- MOTOR_ESTEIRA  out  1  conveyor motor on.
- CMD_ENCHER  out  1  filler command.
- CMD_VEDAR  out  1  sealer command.
- CMD_DESCARTE  out  1  reject pusher; one-cycle pulse.
- CONTAGEM_GARRAFAS  out  4  approved bottles in the current box, 0..DUZIA.
- CONTAGEM_DUZIAS  out  DUZIAS_W  completed boxes.
- CAIXA_CHEIA  out  1  high while waiting for the box swap.
- ALARME_FALHA  out  1  high in FALHA.
- ESTADO  out  3  current state encoding, for debug and display.

Behaviour:
- Moore outputs, decoded from the registered state.
- Reset values: every output is 0; state is PARADO; all counters are 0.
- PARADO: all commands off. Go to AVANCA when START=1 and STOP=0.
- AVANCA: MOTOR_ESTEIRA=1. Go to ENCHENDO on GARRAFA_POSICIONADA=1.
- ENCHENDO: CMD_ENCHER=1. Go to VEDANDO on GARRAFA_CHEIA=1.
- VEDANDO: CMD_VEDAR=1. Go to INSPECIONANDO on GARRAFA_VEDADA=1.
- INSPECIONANDO:
  - Window counter is cleared on entry.
  - If GARRAFA_APROVADA=1 in any of the INSPECAO_CICLOS cycles: CONTAGEM_GARRAFAS+1 on the transition edge, go to LIBERA.
  - If the window expires without approval: go to DESCARTE.
- DESCARTE: CMD_DESCARTE=1 for exactly one cycle, then go to LIBERA. The bottle is not counted.
- LIBERA: MOTOR_ESTEIRA=1 until GARRAFA_POSICIONADA=0, then exit with this priority:
  1. If CONTAGEM_GARRAFAS==DUZIA, go to CAIXA_CHEIA.
  2. Else if STOP=1 or START=0, go to PARADO.
  3. Else go to AVANCA.
- CAIXA_CHEIA: CAIXA_CHEIA=1, motor off. On TROCA_CAIXA=1: CONTAGEM_GARRAFAS:=0, CONTAGEM_DUZIAS+1 (wraps modulo 2^DUZIAS_W), then go to PARADO if STOP=1, else AVANCA.
- Watchdog:
  - Counter is cleared on every state change and counts only in AVANCA, ENCHENDO, VEDANDO and LIBERA.
  - If it reaches TIMEOUT_CICLOS-1 while the exit condition is false, go to FALHA.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- FALHA: all commands off, ALARME_FALHA=1; sticky. RECONHECE_FALHA=1 returns to PARADO; the counters are kept.
- STOP mid-bottle has no effect until LIBERA completes. A bottle is never abandoned under a station.
- RESET asserted mid-operation forces PARADO and zero counts immediately (asynchronous); release is synchronous to CLOCK.
- State encoding (ESTADO): PARADO=0, AVANCA=1, ENCHENDO=2, VEDANDO=3, INSPECIONANDO=4, DESCARTE=5, LIBERA=6, CAIXA_CHEIA=7. FALHA is a separate flag-state and reports ESTADO=7 with ALARME_FALHA=1.

Optional Feature:
- Macro: CONTADOR_REJEITADAS_EN.
- With the macro defined:
  - Adds output CONTAGEM_REJEITADAS [7:0], which increments on every DESCARTE entry, saturates at 255 and clears only on RESET.
  - Three consecutive rejects force FALHA. The consecutive count clears on any approval.
- Without the macro: the port and logic are absent, and rejects never cause a fault.

Decomposition:
- Package linha_pkg holds:
  - state encoding localparams;
  - the default DUZIA, TIMEOUT_CICLOS and INSPECAO_CICLOS values;
  - the ESTADO width.
- One sub-module, temporizador_watchdog:
  - Inputs: clear, enable.
  - Output: expirado at TIMEOUT_CICLOS-1.
  - Reused for the inspection window by a second instance with the limit set to INSPECAO_CICLOS.

Test Plan:
1. Reset then START=1; bottle arrives after 5 cycles and each station responds in 3 cycles, approval in window → sequence AVANCA→ENCHENDO→VEDANDO→INSPECIONANDO→LIBERA; CONTAGEM_GARRAFAS=1; CMD_DESCARTE never pulses.
2. 12 approved bottles → CAIXA_CHEIA=1 with CONTAGEM_GARRAFAS=12 and motor off; TROCA_CAIXA pulse → CONTAGEM_GARRAFAS=0, CONTAGEM_DUZIAS=1, state AVANCA.
3. GARRAFA_APROVADA held 0 for 8 cycles → exactly one CMD_DESCARTE pulse; count unchanged; line continues to AVANCA.
4. GARRAFA_CHEIA never asserts (TIMEOUT_CICLOS=20 in bench) → FALHA on the 20th cycle in ENCHENDO with ALARME_FALHA=1; RECONHECE_FALHA → PARADO with counts preserved.
5. STOP raised during VEDANDO → bottle finishes inspection and LIBERA, then PARADO; count includes that bottle.
6. RESET pulse mid-ENCHENDO with count=7 → all outputs 0 and counts 0 immediately; with CONTADOR_REJEITADAS_EN, 3 rejects in a row → FALHA and CONTAGEM_REJEITADAS=3.
